// File: rtl/digit_input_conditioner.sv
// digit_input_conditioner
//   Debounces the level-held read strobe into exactly one digit event per
//   press and buffers the digits in a first-word-fall-through FIFO that the
//   matcher drains with a valid/ready handshake. Drops are flagged by a
//   sticky overflow bit.
//
// Ports
//   clock           single clock, rising edge
//   reset           synchronous, active-high
//   read            raw press strobe, high for the whole press
//   four_bit_input  digit presented with read
//   digit_out       FIFO head digit
//   digit_valid     FIFO not empty
//   digit_ready     consumer takes the head when digit_valid && digit_ready
//   fifo_count      stored entries, 0..DEPTH
//   overflow        sticky, a press was dropped on a full FIFO
//
// Press detector states
//   state        | meaning
//   IDLE         | armed, waiting for read
//   PRESS_WAIT   | read high, counting stable samples of cand
//   HELD         | press accepted, waiting for read to drop
//   RELEASE_WAIT | read low, counting stable low samples before re-arming

module digit_input_conditioner #(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       read,
  input  logic [3:0] four_bit_input,
  output logic [3:0] digit_out,
  output logic       digit_valid,
  input  logic       digit_ready,
  output logic [4:0] fifo_count,
  output logic       overflow
);

  localparam int                PTR_W      = $clog2(DEPTH);
  localparam logic [3:0]        STABLE     = 4'(STABLE_CYCLES);
  localparam logic [4:0]        FULL_COUNT = 5'(DEPTH);
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic [3:0] cnt_inc;
  logic       push;

  assign cnt_inc = cnt + 4'd1;

  // In PRESS_WAIT the push only fires when the input equals cand, so the
  // live input is always the digit to store.
  always_comb begin
    push = 1'b0;
    case (state)
      IDLE:       push = read && (STABLE == 4'd1);
      PRESS_WAIT: push = read && (four_bit_input == cand) && (cnt_inc == STABLE);
      default:    push = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      cand  <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (read) begin
            cnt   <= 4'd1;
            cand  <= four_bit_input;
            state <= (STABLE == 4'd1) ? HELD : PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (!read) begin
            state <= IDLE;
          end else if (four_bit_input != cand) begin
            cand <= four_bit_input;
            cnt  <= 4'd1;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == STABLE) state <= HELD;
          end
        end
        HELD: begin
          // With a one-sample window this low sample already completes the release.
          if (!read) begin
            cnt   <= 4'd1;
            state <= (STABLE == 4'd1) ? IDLE : RELEASE_WAIT;
          end
        end
        RELEASE_WAIT: begin
          if (read) begin
            state <= HELD;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == STABLE) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [3:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             full;
  logic             pop;
  logic             accept;

  assign digit_valid = (fifo_count != 5'd0);
  assign digit_out   = mem[rd_ptr];
  assign full        = (fifo_count == FULL_COUNT);
  assign pop         = digit_valid && digit_ready;
  // A pop on the same edge frees the slot, so a full FIFO can still accept.
  assign accept      = push && (!full || pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= 5'd0;
      overflow   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 4'd0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= four_bit_input;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;
      if (accept && !pop)      fifo_count <= fifo_count + 5'd1;
      else if (!accept && pop) fifo_count <= fifo_count - 5'd1;
      if (push && !accept) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_digit_input_conditioner.sv
module tb_digit_input_conditioner;

  localparam int S = 4;
  localparam int D = 8;

  logic       clock = 1'b0;
  logic       reset;
  logic       read;
  logic [3:0] four_bit_input;
  logic [3:0] digit_out;
  logic       digit_valid;
  logic       digit_ready;
  logic [4:0] fifo_count;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  digit_input_conditioner #(.STABLE_CYCLES(S), .DEPTH(D)) dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .four_bit_input (four_bit_input),
    .digit_out      (digit_out),
    .digit_valid    (digit_valid),
    .digit_ready    (digit_ready),
    .fifo_count     (fifo_count),
    .overflow       (overflow)
  );

  always #5 clock = ~clock;

  // Reference model: a press is accepted when the detector is armed and the
  // last S samples are all high with one digit; it re-arms after S
  // consecutive low samples. The FIFO is a plain queue.
  logic [3:0] mq[$];
  logic [4:0] hist[$];
  bit         m_ovf = 1'b0;
  bit         armed = 1'b1;
  bit         do_pop, do_push, all_hi, all_lo;

  always @(posedge clock) begin
    if (reset) begin
      mq.delete();
      hist.delete();
      m_ovf = 1'b0;
      armed = 1'b1;
    end else begin
      do_pop  = (mq.size() > 0) && digit_ready;
      do_push = 1'b0;
      hist.push_back({read, four_bit_input});
      if (hist.size() > S) void'(hist.pop_front());
      if (hist.size() == S) begin
        all_hi = 1'b1;
        all_lo = 1'b1;
        foreach (hist[i]) begin
          if (!hist[i][4] || hist[i][3:0] != hist[S-1][3:0]) all_hi = 1'b0;
          if (hist[i][4]) all_lo = 1'b0;
        end
        if (armed && all_hi) begin
          do_push = 1'b1;
          armed   = 1'b0;
        end else if (!armed && all_lo) begin
          armed = 1'b1;
        end
      end
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        if (mq.size() < D) mq.push_back(four_bit_input);
        else m_ovf = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic hold(input logic r, input logic [3:0] d, input int n);
    read           = r;
    four_bit_input = d;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; read = 1'b0; four_bit_input = 4'd0; digit_ready = 1'b0;
    repeat (3) tick();
    checks++; if (digit_out !== 4'd0) begin errors++; $display("FAIL reset_digit_out got=%0h exp=0", digit_out); end
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", digit_valid); end
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
    reset = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL idle_valid cyc=%0d got=%0b exp=0", i, digit_valid); end
    end
  endtask

  task automatic test_press_train();
    logic [3:0] exp_d [4];
    exp_d[0] = 4'd0; exp_d[1] = 4'd1; exp_d[2] = 4'd3; exp_d[3] = 4'd0;
    digit_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      read = 1'b1; four_bit_input = exp_d[k];
      repeat (S - 1) tick();
      checks++; if (fifo_count !== 5'(k)) begin errors++; $display("FAIL train_early k=%0d got=%0d exp=%0d", k, fifo_count, k); end
      tick();
      checks++; if (fifo_count !== 5'(k + 1)) begin errors++; $display("FAIL train_latency k=%0d got=%0d exp=%0d", k, fifo_count, k + 1); end
      hold(1'b1, exp_d[k], 30 - S);
      hold(1'b0, exp_d[k], 30);
    end
    checks++; if (fifo_count !== 5'd4) begin errors++; $display("FAIL train_count got=%0d exp=4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL train_overflow got=%0b exp=0", overflow); end
    digit_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (digit_valid !== 1'b1 || digit_out !== exp_d[i]) begin
        errors++; $display("FAIL train_drain i=%0d got=%0h/%0b exp=%0h/1", i, digit_out, digit_valid, exp_d[i]);
      end
      tick();
    end
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL train_empty got=%0b exp=0", digit_valid); end
    digit_ready = 1'b0;
  endtask

  task automatic test_glitch();
    digit_ready = 1'b0;
    hold(1'b1, 4'd7, 2);
    hold(1'b0, 4'd7, 10);
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL glitch_short got=%0d exp=0", fifo_count); end
    hold(1'b1, 4'd5, 2);
    hold(1'b1, 4'd6, 10);
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL glitch_change_count got=%0d exp=1", fifo_count); end
    checks++; if (digit_out !== 4'd6) begin errors++; $display("FAIL glitch_change_digit got=%0h exp=6", digit_out); end
    hold(1'b0, 4'd6, 1);
    hold(1'b1, 4'd6, 10);
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL glitch_held_drop got=%0d exp=1", fifo_count); end
    hold(1'b0, 4'd0, 10);
    digit_ready = 1'b1;
    tick();
    digit_ready = 1'b0;
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL glitch_drain got=%0b exp=0", digit_valid); end
  endtask

  task automatic test_overflow();
    digit_ready = 1'b0;
    for (int d = 1; d <= 9; d++) begin
      hold(1'b1, 4'(d), 8);
      hold(1'b0, 4'(d), 8);
      if (d == 8) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_at_full got=%0b exp=0", overflow); end
      end
    end
    checks++; if (fifo_count !== 5'd8) begin errors++; $display("FAIL ovf_count got=%0d exp=8", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%0b exp=1", overflow); end
    digit_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      checks++; if (digit_out !== 4'(i)) begin errors++; $display("FAIL ovf_drain i=%0d got=%0h exp=%0h", i, digit_out, i); end
      tick();
    end
    digit_ready = 1'b0;
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", digit_valid); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%0b exp=1", overflow); end
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_reset got=%0b exp=0", overflow); end
  endtask

  task automatic test_full_concurrent_pop();
    logic [3:0] exp_d [D];
    digit_ready = 1'b0;
    for (int i = 0; i < D; i++) begin
      exp_d[i] = 4'($urandom_range(0, 15));
      hold(1'b1, exp_d[i], 6);
      hold(1'b0, exp_d[i], 6);
    end
    read = 1'b1; four_bit_input = 4'hA;
    repeat (S - 1) tick();
    digit_ready = 1'b1;
    tick();
    digit_ready = 1'b0;
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop_overflow got=%0b exp=0", overflow); end
    checks++; if (fifo_count !== 5'd8) begin errors++; $display("FAIL fullpop_count got=%0d exp=8", fifo_count); end
    hold(1'b1, 4'hA, 4);
    hold(1'b0, 4'hA, 8);
    digit_ready = 1'b1;
    for (int i = 1; i <= D; i++) begin
      logic [3:0] e;
      e = (i == D) ? 4'hA : exp_d[i];
      checks++; if (digit_out !== e) begin errors++; $display("FAIL fullpop_drain i=%0d got=%0h exp=%0h", i, digit_out, e); end
      tick();
    end
    digit_ready = 1'b0;
    checks++; if (digit_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%0b exp=0", digit_valid); end
  endtask

  task automatic test_reset_mid();
    digit_ready = 1'b0;
    hold(1'b1, 4'd2, 6); hold(1'b0, 4'd2, 6);
    hold(1'b1, 4'd4, 6); hold(1'b0, 4'd4, 6);
    hold(1'b1, 4'd6, 6); hold(1'b0, 4'd6, 6);
    checks++; if (fifo_count !== 5'd3) begin errors++; $display("FAIL rstmid_fill got=%0d exp=3", fifo_count); end
    hold(1'b1, 4'd9, 2);
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_count got=%0d exp=0", fifo_count); end
    repeat (S - 1) tick();
    checks++; if (fifo_count !== 5'd0) begin errors++; $display("FAIL rstmid_early got=%0d exp=0", fifo_count); end
    tick();
    checks++; if (fifo_count !== 5'd1) begin errors++; $display("FAIL rstmid_push got=%0d exp=1", fifo_count); end
    checks++; if (digit_out !== 4'd9) begin errors++; $display("FAIL rstmid_digit got=%0h exp=9", digit_out); end
    hold(1'b0, 4'd9, 8);
    digit_ready = 1'b1; tick(); digit_ready = 1'b0;
  endtask

  task automatic test_random();
    int cyc = 0;
    logic [3:0] d = 4'd0;
    while (cyc < 2000) begin
      int len;
      read = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) d = 4'($urandom_range(0, 15));
      four_bit_input = d;
      len = $urandom_range(1, 10);
      for (int j = 0; j < len; j++) begin
        digit_ready = ($urandom_range(0, 7) < ((cyc < 1000) ? 1 : 5));
        tick();
        cyc++;
        checks++; if (fifo_count !== 5'(mq.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, fifo_count, mq.size()); end
        checks++; if (digit_valid !== (mq.size() > 0)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%0b exp=%0b", cyc, digit_valid, mq.size() > 0); end
        checks++; if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_overflow cyc=%0d got=%0b exp=%0b", cyc, overflow, m_ovf); end
        if (mq.size() > 0) begin
          checks++; if (digit_out !== mq[0]) begin errors++; $display("FAIL rnd_digit cyc=%0d got=%0h exp=%0h", cyc, digit_out, mq[0]); end
        end
      end
    end
    digit_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; four_bit_input = 4'd0; digit_ready = 1'b0;
    test_reset();
    test_press_train();
    test_glitch();
    test_overflow();
    test_full_concurrent_pop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
